avl_stream_pkt_mux: RTL and testbench



---
 rtl/avl_stream_pkg.sv | 47 ++++
 rtl/avl_stream_skid2.sv | 69 ++++++
 rtl/avl_stream_pkt_mux.sv | 183 ++++++++++++++++++
 tb/tb_avl_stream_pkt_mux.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_stream_pkg.sv
// Shared definitions for the Avalon-ST packet multiplexer slice:
// arbitration states, default buffer entry layout and the round-robin picker.
package avl_stream_pkg;

  // Smallest channel space the output channel field is sized for.
  localparam int CH_MIN = 2;

  // Default geometry for the reference buffer entry layout.
  localparam int DEF_WIDTH  = 512;
  localparam int DEF_MAX_CH = 4;

  // Widest request vector the round-robin picker handles.
  localparam int RR_MAX = 16;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]             data;
    logic                             sop;
    logic                             eop;
    logic [$clog2(DEF_WIDTH/8)-1:0]   empty;
    logic [$clog2(DEF_MAX_CH)-1:0]    channel;
  } buf_entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // One-hot grant for the first requester after ptr, scanning upward with wrap over n inputs.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input int ptr,
                                                input int n);
    logic [RR_MAX-1:0] pick;
    logic              found;
    int                idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = (ptr + k) % n;
      if (k <= n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/avl_stream_skid2.sv
// Two-entry registered output buffer with a registered full flag, so the
// upstream ready never depends combinationally on the downstream ready.
module avl_stream_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         full_q;
  logic         popW;

  // Occupancy next-state: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    popW    = (count_q != 2'd0) && ready_i;
    count_d = count_q;
    if (push_i && !popW) begin
      count_d = count_q + 2'd1;
    end else if (popW && !push_i) begin
      count_d = count_q - 2'd1;
    end
  end

  // Count and full flag; reset empties the buffer and drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == 2'd2);
    end
  end

  // Entry storage: head is always the presented beat, tail shifts up on pop.
  always_ff @(posedge clk) begin
    if (push_i && popW) begin
      if (count_q == 2'd2) begin
        head_q <= tail_q;
        tail_q <= data_i;
      end else begin
        head_q <= data_i;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) begin
        head_q <= data_i;
      end else begin
        tail_q <= data_i;
      end
    end else if (popW) begin
      head_q <= tail_q;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign full_o  = full_q;

endmodule

// File: rtl/avl_stream_pkt_mux.sv
// N-to-1 Avalon-ST packet multiplexer with round-robin arbitration and
// source-index channel tagging. Define AVL_STREAM_PKT_MUX_LOCK_EN for
// packet-locked arbitration with framing checks; otherwise arbitration is per beat.
module avl_stream_pkt_mux
  import avl_stream_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int NUM_IN = 4,
  parameter int MAX_CH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_IN-1:0]                    in_valid_i,
  output logic [NUM_IN-1:0]                    in_ready_o,
  input  logic [NUM_IN*WIDTH-1:0]              in_data_i,
  input  logic [NUM_IN-1:0]                    in_sop_i,
  input  logic [NUM_IN-1:0]                    in_eop_i,
  input  logic [NUM_IN*$clog2(WIDTH/8)-1:0]    in_empty_i,
  output logic [NUM_IN-1:0]                    in_almost_full_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [WIDTH-1:0]                     out_data_o,
  output logic                                 out_sop_o,
  output logic                                 out_eop_o,
  output logic [$clog2(WIDTH/8)-1:0]           out_empty_o,
  output logic [$clog2((MAX_CH > CH_MIN) ? MAX_CH : CH_MIN)-1:0] out_channel_o,
  input  logic                                 out_almost_full_i,
  output logic                                 proto_err_o
);

  localparam int PTR_W   = $clog2(NUM_IN);
  localparam int EMPTY_W = $clog2(WIDTH/8);
  localparam int CH_W    = $clog2((MAX_CH > CH_MIN) ? MAX_CH : CH_MIN);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [CH_W-1:0]    channel;
  } entry_t;

  logic [PTR_W-1:0]  rr_q;
  logic [RR_MAX-1:0] reqFull;
  logic [RR_MAX-1:0] pickFull;
  logic [PTR_W-1:0]  pickIdx;
  logic              pickAny;
  logic              grantAny;
  logic [PTR_W-1:0]  grantIdx;
  logic              pushW;
  logic              skidFull;
  entry_t            pushEntry;
  entry_t            headEntry;

  // Eligibility: packet starts only when locking, any valid beat otherwise.
  always_comb begin
    reqFull = '0;
    for (int i = 0; i < NUM_IN; i++) begin
`ifdef AVL_STREAM_PKT_MUX_LOCK_EN
      reqFull[i] = in_valid_i[i] & in_sop_i[i];
`else
      reqFull[i] = in_valid_i[i];
`endif
    end
  end

  assign pickFull = rr_pick(reqFull, int'(rr_q), NUM_IN);
  assign pickAny  = |pickFull;

  // Encode the one-hot round-robin pick into a source index.
  always_comb begin
    pickIdx = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (pickFull[k]) begin
        pickIdx = PTR_W'(k);
      end
    end
  end

`ifdef AVL_STREAM_PKT_MUX_LOCK_EN
  arb_state_t       state_q;
  logic [PTR_W-1:0] owner_q;
  logic             proto_err_q;

  assign grantAny = (state_q == ST_LOCKED) ? 1'b1 : pickAny;
  assign grantIdx = (state_q == ST_LOCKED) ? owner_q : pickIdx;

  // Packet-lock FSM: holds the owner until eop, flags framing violations one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_q        <= PTR_W'(NUM_IN - 1);
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!pickAny && (|(in_valid_i & ~in_sop_i))) begin
            proto_err_q <= 1'b1;
          end
          if (pushW) begin
            if (in_eop_i[grantIdx]) begin
              rr_q <= grantIdx;
            end else begin
              state_q <= ST_LOCKED;
              owner_q <= grantIdx;
            end
          end
        end
        ST_LOCKED: begin
          if (pushW) begin
            if (in_sop_i[owner_q]) begin
              proto_err_q <= 1'b1;
            end
            if (in_eop_i[owner_q]) begin
              state_q <= ST_IDLE;
              rr_q    <= owner_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign proto_err_o = proto_err_q;
`else
  assign grantAny = pickAny;
  assign grantIdx = pickIdx;

  // Per-beat round robin: the pointer follows every accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= PTR_W'(NUM_IN - 1);
    end else if (pushW) begin
      rr_q <= grantIdx;
    end
  end

  assign proto_err_o = 1'b0;
`endif

  assign pushW = grantAny && in_valid_i[grantIdx] && !skidFull && !rst;

  // Ready goes only to the granted input, and only while the buffer has room.
  always_comb begin
    in_ready_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready_o[i] = grantAny && (grantIdx == PTR_W'(i)) && !skidFull && !rst;
    end
  end

  // Build the buffer entry from the granted input, tagging it with the source index.
  always_comb begin
    pushEntry.data    = in_data_i[int'(grantIdx)*WIDTH +: WIDTH];
    pushEntry.sop     = in_sop_i[grantIdx];
    pushEntry.eop     = in_eop_i[grantIdx];
    pushEntry.empty   = in_empty_i[int'(grantIdx)*EMPTY_W +: EMPTY_W];
    pushEntry.channel = CH_W'(grantIdx);
  end

  avl_stream_skid2 #(
    .W($bits(entry_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushW),
    .data_i  (pushEntry),
    .ready_i (out_ready_i),
    .valid_o (out_valid_o),
    .data_o  (headEntry),
    .full_o  (skidFull)
  );

  assign out_data_o       = headEntry.data;
  assign out_sop_o        = headEntry.sop;
  assign out_eop_o        = headEntry.eop;
  assign out_empty_o      = headEntry.empty;
  assign out_channel_o    = headEntry.channel;
  assign in_almost_full_o = {NUM_IN{out_almost_full_i}};

endmodule

// File: tb/tb_avl_stream_pkt_mux.sv
// Directed self-checking bench for avl_stream_pkt_mux (4 inputs, 64-bit data).
// Lock-mode steps are built only when AVL_STREAM_PKT_MUX_LOCK_EN is defined.
module tb_avl_stream_pkt_mux;

  localparam int WIDTH   = 64;
  localparam int NUM_IN  = 4;
  localparam int MAX_CH  = 4;
  localparam int EMPTY_W = 3;
  localparam int CH_W    = 2;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [NUM_IN-1:0]           inValid;
  logic [NUM_IN-1:0]           inReady;
  logic [NUM_IN-1:0]           inSop;
  logic [NUM_IN-1:0]           inEop;
  logic [NUM_IN-1:0]           inAlmostFull;
  logic [WIDTH-1:0]            inData [NUM_IN];
  logic [NUM_IN*WIDTH-1:0]     inDataFlat;
  logic [NUM_IN*EMPTY_W-1:0]   inEmptyFlat;
  logic                        outValid;
  logic                        outReady;
  logic [WIDTH-1:0]            outData;
  logic                        outSop;
  logic                        outEop;
  logic [EMPTY_W-1:0]          outEmpty;
  logic [CH_W-1:0]             outChannel;
  logic                        outAlmostFull;
  logic                        protoErr;

  int   tests = 0;
  int   fails = 0;
  int   occ   = 0;
  logic armed = 1'b0;

  avl_stream_pkt_mux #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .MAX_CH (MAX_CH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid_i        (inValid),
    .in_ready_o        (inReady),
    .in_data_i         (inDataFlat),
    .in_sop_i          (inSop),
    .in_eop_i          (inEop),
    .in_empty_i        (inEmptyFlat),
    .in_almost_full_o  (inAlmostFull),
    .out_valid_o       (outValid),
    .out_ready_i       (outReady),
    .out_data_o        (outData),
    .out_sop_o         (outSop),
    .out_eop_o         (outEop),
    .out_empty_o       (outEmpty),
    .out_channel_o     (outChannel),
    .out_almost_full_i (outAlmostFull),
    .proto_err_o       (protoErr)
  );

  always #5 clk = ~clk;

  // Each input carries its own index as the empty value so the pass-through is visible.
  assign inEmptyFlat = {3'd3, 3'd2, 3'd1, 3'd0};

  // Pack the per-input data words into the flat port.
  always_comb begin
    inDataFlat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      inDataFlat[i*WIDTH +: WIDTH] = inData[i];
    end
  end

  // Occupancy model of the output buffer; a push while it holds two beats is an error.
  always @(posedge clk) begin
    if (rst) begin
      occ = 0;
    end else begin
      if (armed) begin
        tests++;
        assert (!((|(inValid & inReady)) && occ == 2)) else begin
          fails++;
          $error("[TB] FAIL push_when_full: observed push with occupancy %0d, required no push", occ);
        end
      end
      occ = occ + int'(|(inValid & inReady)) - int'(outValid & outReady);
    end
  end

  // out.valid must track the modelled occupancy every cycle.
  always @(negedge clk) begin
    if (armed) begin
      tests++;
      assert (outValid === (occ != 0)) else begin
        fails++;
        $error("[TB] FAIL out_valid_vs_occ: observed %0b required %0b", outValid, (occ != 0));
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic v, input logic s, input logic e,
                               input logic [WIDTH-1:0] d);
    inValid[idx] = v;
    inSop[idx]   = s;
    inEop[idx]   = e;
    inData[idx]  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_IN; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, '0);
    outReady      = 1'b1;
    outAlmostFull = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    armed = 1'b1;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_proto_err", protoErr, 0);

    outAlmostFull = 1'b1;
    #1;
    checkOutput("almost_full_hi", inAlmostFull, 4'hF);
    outAlmostFull = 1'b0;
    #1;
    checkOutput("almost_full_lo", inAlmostFull, 4'h0);

    // in[1] starts a packet into a stalled output, then reset lands mid-packet.
    rst      = 1'b0;
    outReady = 1'b0;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 64'h11);
    #1;
    checkOutput("mid_grant_in1", inReady, 4'b0010);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 64'h12);
    tick();
    checkOutput("mid_head_data", outData, 64'h11);
    checkOutput("mid_full_ready", inReady, 4'b0000);
    rst      = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < NUM_IN; i++) applyStimulus(i, 1'b1, 1'b1, 1'b1, 64'h100 + 64'(i));
    #1;
    checkOutput("rst_hold_ready", inReady, 4'b0000);
    tick();
    checkOutput("mid_rst_out_valid", outValid, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_grant_in0", inReady, 4'b0001);

    // All four inputs hold single-beat packets: channels rotate 0,1,2,3,0 at one beat per cycle.
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("rr_valid_%0d", k), outValid, 1);
      checkOutput($sformatf("rr_ch_%0d", k), outChannel, 64'(k % 4));
      checkOutput($sformatf("rr_data_%0d", k), outData, 64'h100 + 64'(k % 4));
    end
    for (int i = 0; i < NUM_IN; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("rr_drain", outValid, 0);

    // Backpressure: output stalls for five cycles while in[2] keeps offering beats.
    applyStimulus(2, 1'b1, 1'b1, 1'b1, 64'h200);
    tick();
    checkOutput("bp_first", outData, 64'h200);
    outReady = 1'b0;
    applyStimulus(2, 1'b1, 1'b1, 1'b1, 64'h201);
    #1;
    checkOutput("bp_ready_room", inReady, 4'b0100);
    tick();
    applyStimulus(2, 1'b1, 1'b1, 1'b1, 64'h202);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("bp_stall_ready_%0d", k), inReady, 4'b0000);
      checkOutput($sformatf("bp_stall_head_%0d", k), outData, 64'h200);
      tick();
    end
    outReady = 1'b1;
    tick();
    checkOutput("bp_release_1", outData, 64'h201);
    checkOutput("bp_release_ready", inReady, 4'b0100);
    tick();
    checkOutput("bp_release_2", outData, 64'h202);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("bp_drain", outValid, 0);

`ifdef AVL_STREAM_PKT_MUX_LOCK_EN
    // in[2] sends a 3-beat packet; in[0] must wait for the whole packet.
    applyStimulus(2, 1'b1, 1'b1, 1'b0, 64'h301);
    #1;
    checkOutput("lock_grant_in2", inReady, 4'b0100);
    tick();
    checkOutput("lock_b1_ch", outChannel, 2);
    checkOutput("lock_b1_data", outData, 64'h301);
    checkOutput("lock_b1_sop", outSop, 1);
    checkOutput("lock_b1_empty", outEmpty, 2);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 64'h300);
    applyStimulus(2, 1'b1, 1'b0, 1'b0, 64'h302);
    #1;
    checkOutput("lock_b2_ready", inReady, 4'b0100);
    tick();
    checkOutput("lock_b2_data", outData, 64'h302);
    applyStimulus(2, 1'b1, 1'b0, 1'b1, 64'h303);
    #1;
    checkOutput("lock_b3_ready", inReady, 4'b0100);
    tick();
    checkOutput("lock_b3_data", outData, 64'h303);
    checkOutput("lock_b3_eop", outEop, 1);
    applyStimulus(2, 1'b0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("lock_release_grant", inReady, 4'b0001);
    tick();
    checkOutput("lock_after_ch", outChannel, 0);
    checkOutput("lock_after_data", outData, 64'h300);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("lock_drain", outValid, 0);

    // Second sop inside a packet: flagged one cycle later, beat still forwarded.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 64'h401);
    tick();
    checkOutput("perr_b1_flag", protoErr, 0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 64'h402);
    tick();
    checkOutput("perr_b2_flag", protoErr, 1);
    checkOutput("perr_b2_data", outData, 64'h402);
    checkOutput("perr_b2_sop", outSop, 1);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 64'h403);
    tick();
    checkOutput("perr_b3_flag", protoErr, 0);
    checkOutput("perr_b3_data", outData, 64'h403);
    // A lone valid input without sop in IDLE never gets a grant and flags every cycle.
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(3, 1'b1, 1'b0, 1'b1, 64'h404);
    #1;
    checkOutput("perr_nosop_ready", inReady, 4'b0000);
    tick();
    checkOutput("perr_nosop_flag_1", protoErr, 1);
    checkOutput("perr_nosop_valid", outValid, 0);
    tick();
    checkOutput("perr_nosop_flag_2", protoErr, 1);
    applyStimulus(3, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("perr_clear", protoErr, 0);
`else
    // Per-beat arbitration: a 3-beat packet on in[1] interleaves with single beats on in[3].
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 64'h501);
    #1;
    checkOutput("il_grant_in1", inReady, 4'b0010);
    tick();
    checkOutput("il_1_ch", outChannel, 1);
    checkOutput("il_1_data", outData, 64'h501);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 64'h502);
    applyStimulus(3, 1'b1, 1'b1, 1'b1, 64'h531);
    #1;
    checkOutput("il_grant_in3", inReady, 4'b1000);
    tick();
    checkOutput("il_2_ch", outChannel, 3);
    checkOutput("il_2_data", outData, 64'h531);
    applyStimulus(3, 1'b1, 1'b1, 1'b1, 64'h532);
    tick();
    checkOutput("il_3_ch", outChannel, 1);
    checkOutput("il_3_data", outData, 64'h502);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 64'h503);
    tick();
    checkOutput("il_4_ch", outChannel, 3);
    checkOutput("il_4_data", outData, 64'h532);
    applyStimulus(3, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("il_5_ch", outChannel, 1);
    checkOutput("il_5_data", outData, 64'h503);
    checkOutput("il_5_eop", outEop, 1);
    checkOutput("il_proto_err", protoErr, 0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("il_drain", outValid, 0);
`endif

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
